// File: rtl/temp_poll_ctrl.sv
// rtl/temp_poll_ctrl.sv - periodic I2C temperature sensor poller driving a byte-level I2C command engine
module temp_poll_ctrl #(
    parameter int         POLL_CYCLES = 100000,
    parameter logic [6:0] DEV_ADDR    = 7'h4B,
    parameter logic [7:0] PTR_REG     = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        trig_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [2:0]  cmd_op_o,
    output logic [7:0]  cmd_wdata_o,
    input  logic        rsp_valid_i,
    input  logic [7:0]  rsp_rdata_i,
    input  logic        rsp_nack_i,
    output logic [15:0] temp_o,
    output logic        temp_valid_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_ACK  = 3'd2;
    localparam logic [2:0] OP_READ_NACK = 3'd3;
    localparam logic [2:0] OP_STOP      = 3'd4;

    localparam int            TW   = $clog2(POLL_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_ABORT_ISSUE,
        S_ABORT_WAIT
    } state_t;

    state_t        state;
    logic [2:0]    step;
    logic [TW-1:0] timer;
    logic [7:0]    msb;
    logic [7:0]    lsb;
    logic [2:0]    step_op;
    logic [7:0]    step_data;
    logic          poll_due;

    always_comb begin
        step_op   = OP_START;
        step_data = 8'h00;
        case (step)
            3'd0: step_op = OP_START;
            3'd1: begin step_op = OP_WRITE; step_data = {DEV_ADDR, 1'b0}; end
            3'd2: begin step_op = OP_WRITE; step_data = PTR_REG; end
            3'd3: step_op = OP_START;
            3'd4: begin step_op = OP_WRITE; step_data = {DEV_ADDR, 1'b1}; end
            3'd5: step_op = OP_READ_ACK;
            3'd6: step_op = OP_READ_NACK;
            default: step_op = OP_STOP;
        endcase
    end

    assign poll_due = en_i && (timer == LAST);

    // Command outputs are raised one cycle after entering an issue state, which
    // guarantees an idle cycle between a response and the following command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            step         <= 3'd0;
            timer        <= '0;
            msb          <= 8'h00;
            lsb          <= 8'h00;
            cmd_valid_o  <= 1'b0;
            cmd_op_o     <= 3'd0;
            cmd_wdata_o  <= 8'h00;
            temp_o       <= 16'h0000;
            temp_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            temp_valid_o <= 1'b0;
            timer        <= '0;
            case (state)
                S_IDLE: begin
                    if (en_i && !poll_due)
                        timer <= timer + 1'b1;
                    if (trig_i || poll_due) begin
                        state  <= S_ISSUE;
                        step   <= 3'd0;
                        busy_o <= 1'b1;
                        err_o  <= 1'b0;
                        timer  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!cmd_valid_o) begin
                        cmd_valid_o <= 1'b1;
                        cmd_op_o    <= step_op;
                        cmd_wdata_o <= step_data;
                    end else if (cmd_ready_i) begin
                        cmd_valid_o <= 1'b0;
                        cmd_op_o    <= 3'd0;
                        cmd_wdata_o <= 8'h00;
                        state       <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_valid_i) begin
                        if (step_op == OP_READ_ACK)
                            msb <= rsp_rdata_i;
                        if (step_op == OP_READ_NACK)
                            lsb <= rsp_rdata_i;
                        if (step_op == OP_WRITE && rsp_nack_i) begin
                            err_o <= 1'b1;
                            state <= S_ABORT_ISSUE;
                        end else if (step == 3'd7) begin
                            temp_o       <= {msb, lsb};
                            temp_valid_o <= 1'b1;
                            busy_o       <= 1'b0;
                            step         <= 3'd0;
                            state        <= S_IDLE;
                        end else begin
                            step  <= step + 3'd1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ABORT_ISSUE: begin
                    if (!cmd_valid_o) begin
                        cmd_valid_o <= 1'b1;
                        cmd_op_o    <= OP_STOP;
                        cmd_wdata_o <= 8'h00;
                    end else if (cmd_ready_i) begin
                        cmd_valid_o <= 1'b0;
                        cmd_op_o    <= 3'd0;
                        state       <= S_ABORT_WAIT;
                    end
                end
                S_ABORT_WAIT: begin
                    if (rsp_valid_i) begin
                        busy_o <= 1'b0;
                        step   <= 3'd0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/temp_poll_ctrl.md
TEMP_POLL_CTRL -- requirements
Module: temp_poll_ctrl

Interface
REQ-001 Parameter POLL_CYCLES, default 100000, clk cycles between automatic temperature reads (min 16).
REQ-002 Parameter DEV_ADDR, default 7'h4B, 7-bit I2C address of the board temperature sensor.
REQ-003 Parameter PTR_REG, default 8'h00, sensor register pointer for the 16-bit temperature value.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en_i  in  1  enables periodic polling.
REQ-007 trig_i  in  1  single-cycle request for an immediate read.
REQ-008 cmd_valid_o  out  1  command to byte-level I2C engine valid.
REQ-009 cmd_ready_i  in  1  engine accepts command.
REQ-010 cmd_op_o  out  3  0=START, 1=WRITE, 2=READ_ACK, 3=READ_NACK, 4=STOP.
REQ-011 cmd_wdata_o  out  8  byte for WRITE; 0 otherwise.
REQ-012 rsp_valid_i  in  1  single-cycle completion of the accepted command.
REQ-013 rsp_rdata_i  in  8  read byte, valid with rsp_valid_i for READ ops.
REQ-014 rsp_nack_i  in  1  slave NACK, valid with rsp_valid_i for WRITE ops.
REQ-015 temp_o  out  16  last good reading, {MSB,LSB}.
REQ-016 temp_valid_o  out  1  one-cycle pulse when temp_o updates.
REQ-017 busy_o  out  1  transaction sequence in progress.
REQ-018 err_o  out  1  sticky NACK flag; cleared at start of next sequence.

Function
REQ-019 Sequence, fixed order, steps 0-7: START; WRITE {DEV_ADDR,0}; WRITE PTR_REG; START (repeated); WRITE {DEV_ADDR,1}; READ_ACK (MSB); READ_NACK (LSB); STOP.
REQ-020 FSM states: IDLE, ISSUE, WAIT_RSP, ABORT_ISSUE, ABORT_WAIT.
REQ-021 IDLE->ISSUE, step=0, when trig_i=1, or when poll timer expires with en_i=1; busy_o=1 from the next cycle.
REQ-022 ISSUE: cmd_valid_o=1 with op/data of current step, held stable until cmd_ready_i=1; handshake cycle -> WAIT_RSP.
REQ-023 WAIT_RSP: cmd_valid_o=0; on rsp_valid_i: step 7 -> IDLE; else step+1, -> ISSUE next cycle.
REQ-024 Minimum spacing: one idle cycle between rsp_valid_i and next cmd_valid_o.
REQ-025 READ_ACK response latches MSB; READ_NACK response latches LSB internally.
REQ-026 STOP response: temp_o <= {MSB,LSB} and temp_valid_o=1 in the same cycle; busy_o=0 the cycle after.
REQ-027 rsp_nack_i=1 on any WRITE response: err_o<=1, -> ABORT_ISSUE; issue STOP, await response, -> IDLE; temp_o unchanged, no temp_valid_o.
REQ-028 rsp_valid_i outside WAIT_RSP/ABORT_WAIT is ignored; rsp_nack_i ignored on READ/START/STOP responses.
REQ-029 Poll timer: counts 0..POLL_CYCLES-1 only in IDLE with en_i=1; expiry at POLL_CYCLES-1, counter then 0.
REQ-030 Timer held at 0 when en_i=0 and while busy; restarts from 0 on return to IDLE.
REQ-031 trig_i while busy ignored, not queued; trig_i and timer expiry in same cycle start one sequence.
REQ-032 err_o cleared on the IDLE->ISSUE transition.

Reset
REQ-033 rst=1 on a clk edge: state IDLE, step 0, timer 0, cmd_valid_o=0, cmd_op_o=0, cmd_wdata_o=0, temp_o=16'h0000, temp_valid_o=0, busy_o=0, err_o=0.
REQ-034 Reset mid-sequence aborts immediately; no STOP issued; engine resets with the same rst.

Verification
REQ-035 trig_i pulse, engine always ready, rsp 2 cycles after accept, read bytes 8'h0C,8'h80 -> 8 commands in REQ-019 order, addr bytes 8'h96/8'h97, temp_o=16'h0C80, one temp_valid_o pulse.
REQ-036 NACK on step 1 -> STOP issued, err_o=1, temp_o keeps prior 16'h0C80, no temp_valid_o; next trig_i clears err_o.
REQ-037 en_i=1, POLL_CYCLES=16, immediate responses -> sequence start every 16 + sequence-length cycles, no overlap.
REQ-038 cmd_ready_i low 5 cycles in step 3 -> cmd_valid_o, op=0, data=0 stable throughout; single accept.
REQ-039 trig_i during busy and simultaneous with timer expiry -> exactly one sequence each case.
REQ-040 rst asserted during WAIT_RSP step 5 -> all outputs at REQ-033 values next cycle; no STOP.
